// File: rtl/cell_decoder.sv
// cell_decoder: decodes a stream of pixel writes into a 7x7 board of tile states.
// A tile is reported once all 225 of its interior pixels arrive consecutively
// with one colour. Optional macro CELL_DECODER_ERR_EN adds the abort_count and
// err_pulse outputs.
//
// state  | meaning
// IDLE   | no tile in progress
// ACCUM  | counting matching pixels of the latched tile
// REPORT | one-cycle tile report, board write
module cell_decoder (
    input  logic       clk,
    input  logic       resetGame,
    input  logic       writeEn,
    input  logic [7:0] x_in,
    input  logic [6:0] y_in,
    input  logic [2:0] colour_in,
    input  logic [2:0] query_col,
    input  logic [2:0] query_row,
    output logic [1:0] query_state,
    output logic       cell_valid,
    output logic [2:0] cell_col,
    output logic [2:0] cell_row,
    output logic [1:0] cell_state
`ifdef CELL_DECODER_ERR_EN
    ,
    output logic [7:0] abort_count,
    output logic       err_pulse
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    localparam logic [7:0] TILE_PIXELS = 8'd225;

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_count;
    logic [2:0] r_col;
    logic [2:0] r_row;
    logic [2:0] r_colour;
    logic [1:0] r_board [0:6][0:6];

    logic       w_in_grid;
    logic       w_accept;
    logic       w_match;
    logic [6:0] w_dx;
    logic [6:0] w_dy;
    logic [2:0] w_col;
    logic [2:0] w_row;

    function automatic logic [1:0] colour_to_state(input logic [2:0] c);
        case (c)
            3'b111:  return 2'b00;
            3'b100:  return 2'b01;
            3'b110:  return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    // The grid spans at most 112 pixels per axis, so 7-bit offsets suffice
    // once the in-grid test has passed.
    assign w_in_grid = (x_in >= 8'd25) && (x_in <= 8'd136) &&
                       (y_in >= 7'd10) && (y_in <= 7'd121);
    assign w_dx      = 7'(x_in - 8'd25);
    assign w_dy      = y_in - 7'd10;
    assign w_col     = w_dx[6:4];
    assign w_row     = w_dy[6:4];
    assign w_accept  = writeEn && w_in_grid &&
                       (w_dx[3:0] != 4'hF) && (w_dy[3:0] != 4'hF);
    assign w_match   = (w_col == r_col) && (w_row == r_row) && (colour_in == r_colour);

    // State register
    always_ff @(posedge clk) begin
        if (resetGame) r_state <= S_IDLE;
        else           r_state <= w_state_next;
    end

    // Next-state logic; REPORT behaves like IDLE so a pixel in that cycle is not lost
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_REPORT: w_state_next = w_accept ? S_ACCUM : S_IDLE;
            S_ACCUM: begin
                if (w_accept && w_match && (r_count == TILE_PIXELS - 8'd1))
                    w_state_next = S_REPORT;
                else
                    w_state_next = S_ACCUM;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        cell_valid = (r_state == S_REPORT);
`ifdef CELL_DECODER_ERR_EN
        err_pulse  = (r_state == S_REPORT) && (cell_state == 2'b11);
`endif
    end

    // Tile latch and matching-pixel counter
    always_ff @(posedge clk) begin
        if (resetGame) begin
            r_count  <= 8'd0;
            r_col    <= 3'd0;
            r_row    <= 3'd0;
            r_colour <= 3'd0;
        end else if (r_state == S_ACCUM) begin
            if (w_accept && w_match) begin
                r_count <= (r_count >= TILE_PIXELS) ? TILE_PIXELS : r_count + 8'd1;
            end else if (w_accept) begin
                r_col    <= w_col;
                r_row    <= w_row;
                r_colour <= colour_in;
                r_count  <= 8'd1;
            end
        end else if (w_accept) begin
            r_col    <= w_col;
            r_row    <= w_row;
            r_colour <= colour_in;
            r_count  <= 8'd1;
        end else begin
            r_count  <= 8'd0;
        end
    end

    // Report registers load on entry to REPORT and hold until the next report
    always_ff @(posedge clk) begin
        if (resetGame) begin
            cell_col   <= 3'd0;
            cell_row   <= 3'd0;
            cell_state <= 2'b00;
        end else if ((r_state == S_ACCUM) && (w_state_next == S_REPORT)) begin
            cell_col   <= r_col;
            cell_row   <= r_row;
            cell_state <= colour_to_state(r_colour);
        end
    end

    // Board storage, written at the end of the REPORT cycle
    always_ff @(posedge clk) begin
        if (resetGame) begin
            for (int r = 0; r < 7; r++)
                for (int c = 0; c < 7; c++)
                    r_board[r][c] <= 2'b00;
        end else if ((r_state == S_REPORT) && (cell_row < 3'd7) && (cell_col < 3'd7)) begin
            r_board[cell_row][cell_col] <= cell_state;
        end
    end

    assign query_state = ((query_row < 3'd7) && (query_col < 3'd7)) ?
                         r_board[query_row][query_col] : 2'b00;

`ifdef CELL_DECODER_ERR_EN
    // Count aborted tiles, saturating
    always_ff @(posedge clk) begin
        if (resetGame)
            abort_count <= 8'd0;
        else if ((r_state == S_ACCUM) && w_accept && !w_match && (abort_count != 8'hFF))
            abort_count <= abort_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_cell_decoder.sv
// Scoreboard bench for cell_decoder: a tile-level reference model pushes
// expected reports; a negedge monitor pops and compares them.
module tb_cell_decoder;

    logic       clk = 1'b0;
    logic       resetGame = 1'b1;
    logic       writeEn = 1'b0;
    logic [7:0] x_in = 8'd0;
    logic [6:0] y_in = 7'd0;
    logic [2:0] colour_in = 3'd0;
    logic [2:0] query_col = 3'd0;
    logic [2:0] query_row = 3'd0;
    logic [1:0] query_state;
    logic       cell_valid;
    logic [2:0] cell_col;
    logic [2:0] cell_row;
    logic [1:0] cell_state;
`ifdef CELL_DECODER_ERR_EN
    logic [7:0] abort_count;
    logic       err_pulse;
`endif

    cell_decoder dut (
        .clk(clk), .resetGame(resetGame), .writeEn(writeEn),
        .x_in(x_in), .y_in(y_in), .colour_in(colour_in),
        .query_col(query_col), .query_row(query_row), .query_state(query_state),
        .cell_valid(cell_valid), .cell_col(cell_col), .cell_row(cell_row),
        .cell_state(cell_state)
`ifdef CELL_DECODER_ERR_EN
        , .abort_count(abort_count), .err_pulse(err_pulse)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int col; int row; int st; int at; } exp_t;
    exp_t q[$];

    // Reference model: current run of identical accepted pixels
    bit m_active = 0;
    int m_col, m_row, m_colour, m_cnt;
    int m_board [7][7];
    int m_abort = 0;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int map_colour(int c);
        if (c == 7) return 0;
        if (c == 4) return 1;
        if (c == 6) return 2;
        return 3;
    endfunction

    task automatic model_reset();
        m_active = 0;
        m_cnt = 0;
        m_abort = 0;
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 7; c++)
                m_board[r][c] = 0;
    endtask

    task automatic model_step(bit we, int x, int y, int c);
        int col, row;
        exp_t e;
        if (!we || x < 25 || x > 136 || y < 10 || y > 121) return;
        if ((x - 25) % 16 == 15 || (y - 10) % 16 == 15) return;
        col = (x - 25) / 16;
        row = (y - 10) / 16;
        if (m_active && col == m_col && row == m_row && c == m_colour) begin
            m_cnt++;
        end else begin
            if (m_active && m_abort < 255) m_abort++;
            m_active = 1;
            m_col = col; m_row = row; m_colour = c; m_cnt = 1;
        end
        if (m_cnt == 225) begin
            e.col = col; e.row = row; e.st = map_colour(c); e.at = cyc + 1;
            q.push_back(e);
            m_board[row][col] = e.st;
            m_active = 0;
        end
    endtask

    // Drive one pixel; it is sampled at the following rising edge
    task automatic pix(bit we, int x, int y, int c);
        @(posedge clk); #1;
        resetGame = 0;
        writeEn   = we;
        x_in      = 8'(x);
        y_in      = 7'(y);
        colour_in = 3'(c);
        model_step(we, x, y, c);
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk); #1;
            writeEn = 0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        resetGame = 1;
        writeEn   = 0;
        model_reset();
        @(posedge clk); #1;
        resetGame = 0;
        check("rst_valid", int'(cell_valid), 0);
        check("rst_col", int'(cell_col), 0);
        check("rst_row", int'(cell_row), 0);
        check("rst_state", int'(cell_state), 0);
    endtask

    task automatic check_board();
        int exp;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                query_row = 3'(r);
                query_col = 3'(c);
                #1;
                exp = (r < 7 && c < 7) ? m_board[r][c] : 0;
                check($sformatf("board_r%0d_c%0d", r, c), int'(query_state), exp);
            end
    endtask

    task automatic settle();
        idle(4);
        check("missing_valid", q.size(), 0);
        check_board();
`ifdef CELL_DECODER_ERR_EN
        check("abort_count", int'(abort_count), m_abort);
`endif
    endtask

    // Stream npix interior pixels of a tile in raster order.
    // noise: 0 none, 1 random ignored pixels, 2 fixed x=40/x=137/y=5 per line
    task automatic tile(int col, int row, int c, int npix, int gap, int noise);
        int ox, oy, bx, by;
        bx = 25 + 16 * col;
        by = 10 + 16 * row;
        for (int k = 0; k < npix; k++) begin
            ox = k % 15;
            oy = k / 15;
            pix(1, bx + ox, by + oy, c);
            if (noise == 1 && $urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 4))
                    0: pix(0, bx + ox, by + oy, c);
                    1: pix(1, 137, by + oy, c);
                    2: pix(1, bx + ox, 5, c);
                    3: pix(1, bx + 15, by + oy, c);
                    default: pix(1, bx + ox, by + 15, c);
                endcase
            end
            if (ox == 14) begin
                if (noise == 2) begin
                    pix(1, 40, by + oy, c);
                    pix(1, 137, by + oy, c);
                    pix(1, bx + ox, 5, c);
                end
                if (gap > 0 && k != npix - 1) begin
                    for (int g = 0; g < gap; g++) pix(0, bx + ox, by + oy, c);
                end
            end
        end
    endtask

    // Monitor: every cell_valid cycle must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (cell_valid === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = q.pop_front();
                check("cell_col", int'(cell_col), e.col);
                check("cell_row", int'(cell_row), e.row);
                check("cell_state", int'(cell_state), e.st);
                check("valid_cycle", cyc, e.at);
`ifdef CELL_DECODER_ERR_EN
                check("err_pulse", int'(err_pulse), (e.st == 3) ? 1 : 0);
`endif
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        do_reset();
        check_board();

        tile(2, 3, 4, 225, 0, 0);
        settle();

        tile(2, 3, 6, 225, 5, 0);
        settle();

        tile(0, 1, 4, 100, 0, 0);
        tile(4, 1, 4, 225, 0, 0);
        settle();

        for (int y = 10; y <= 24; y++)
            for (int x = 25; x <= 135; x++)
                pix(1, x, y, 7);
        tile(5, 0, 4, 225, 0, 0);
        settle();

        tile(1, 5, 6, 200, 0, 0);
        do_reset();
        settle();
        tile(6, 6, 4, 225, 0, 0);
        settle();

        tile(3, 2, 6, 225, 0, 2);
        settle();

        for (int i = 0; i < 16; i++) begin
            int col, row, gap;
            col = $urandom_range(0, 6);
            row = $urandom_range(0, 6);
            gap = $urandom_range(0, 2);
            if ($urandom_range(0, 2) == 0)
                tile($urandom_range(0, 6), $urandom_range(0, 6),
                     $urandom_range(0, 7), $urandom_range(1, 224), 0, 1);
            tile(col, row, i % 8, 225, gap, 1);
            if (i % 3 == 0) settle();
        end
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
